trace_packet_decoder: RTL

- Consumes the tracer's packet stream (type + 23-bit payload + strobe, one packet per mclk max) and reconstructs absolute RAM-bus events: read/write word, full word address, byte lanes, data and absolute cycle timestamp.
- Sits at the far end of the trace channel: loopback self-check on the board, and on-chip replay/compare against a golden trace.
- Buffers decoded events in a FIFO with valid/ready output and a sticky overflow flag.

---
 rtl/trace_packet_decoder_pkg.sv | 35 +++
 rtl/trace_packet_decoder_if.sv | 29 ++
 rtl/trace_packet_decoder_event_fifo.sv | 63 ++++++
 rtl/trace_packet_decoder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/trace_packet_decoder_pkg.sv
// Shared constants and types for the trace packet decoder: packet type codes,
// payload field positions and the packed event header layout.
package trace_pkg;

  localparam int ADDR_WIDTH    = 23;
  localparam int PAYLOAD_WIDTH = 23;

  typedef enum logic [1:0] {
    PKT_ADDR  = 2'b00,
    PKT_READ  = 2'b01,
    PKT_WRITE = 2'b10,
    PKT_TIME  = 2'b11
  } pkt_type_e;

  localparam int TS5_MSB  = 22;
  localparam int TS5_LSB  = 18;
  localparam int UBLB_MSB = 17;
  localparam int UBLB_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  typedef struct packed {
    logic                  is_write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            ublb;
    logic [15:0]           data;
  } ev_hdr_t;

  localparam int EV_HDR_WIDTH = $bits(ev_hdr_t);

  function automatic logic [4:0] ts5_of(input logic [PAYLOAD_WIDTH-1:0] payload);
    return payload[TS5_MSB:TS5_LSB];
  endfunction

endpackage

// File: rtl/trace_packet_decoder_if.sv
// Packet input stream and decoded-event valid/ready output of the trace decoder.
// master = tracer/consumer side, slave = decoder side.
interface trace_packet_decoder_if #(
  parameter int TIME_WIDTH = 32
);

  logic                                  packet_strobe;
  logic [1:0]                            packet_type;
  logic [trace_pkg::PAYLOAD_WIDTH-1:0]   packet_payload;

  logic                                  ev_valid;
  logic                                  ev_ready;
  logic                                  ev_is_write;
  logic [trace_pkg::ADDR_WIDTH-1:0]      ev_addr;
  logic [1:0]                            ev_ublb;
  logic [15:0]                           ev_data;
  logic [TIME_WIDTH-1:0]                 ev_time;

  modport master (
    output packet_strobe, packet_type, packet_payload, ev_ready,
    input  ev_valid, ev_is_write, ev_addr, ev_ublb, ev_data, ev_time
  );

  modport slave (
    input  packet_strobe, packet_type, packet_payload, ev_ready,
    output ev_valid, ev_is_write, ev_addr, ev_ublb, ev_data, ev_time
  );

endinterface

// File: rtl/trace_packet_decoder_event_fifo.sv
// trace_event_fifo: synchronous first-word-fall-through FIFO for decoded events.
// A push while full is accepted only if the head leaves in the same cycle.
module trace_event_fifo #(
  parameter int WIDTH      = 74,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign empty    = (count == '0);
  assign full     = count[DEPTH_LOG2];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign head     = mem[rd_ptr];

  always_ff @(posedge mclk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    end
  end

endmodule

// File: rtl/trace_packet_decoder.sv
// Trace packet decoder: rebuilds absolute RAM-bus events from the tracer's packet
// stream and buffers them in an FWFT FIFO. Optional counters: TRACE_DECODER_STATS_EN.
module trace_packet_decoder
  import trace_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int TIME_WIDTH      = 32
) (
  input  logic                   mclk,
  input  logic                   reset,
  input  logic                   clear,
  trace_packet_decoder_if.slave  pkt,
  output logic                   overflow
`ifdef TRACE_DECODER_STATS_EN
  ,
  output logic [31:0]            stat_reads,
  output logic [31:0]            stat_writes,
  output logic [15:0]            stat_drops
`endif
);

  localparam int EV_WIDTH = EV_HDR_WIDTH + TIME_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [TIME_WIDTH-1:0] time_acc;
  logic [TIME_WIDTH-1:0] time_step;
  logic [TIME_WIDTH-1:0] time_next;
  logic                  is_word;

  logic                  push_q;
  ev_hdr_t               push_hdr_q;
  logic [TIME_WIDTH-1:0] push_time_q;

  logic [EV_WIDTH-1:0]   fifo_head;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_ovf;
  logic                  fifo_pop;
  ev_hdr_t               head_hdr;

  always_comb begin
    time_step = '0;
    is_word   = 1'b0;
    if (pkt.packet_strobe) begin
      case (pkt.packet_type)
        PKT_READ, PKT_WRITE: begin
          time_step = TIME_WIDTH'(ts5_of(pkt.packet_payload));
          is_word   = 1'b1;
        end
        PKT_TIME: time_step = TIME_WIDTH'(pkt.packet_payload);
        default:  time_step = '0;
      endcase
    end
    time_next = time_acc + time_step;
  end

  // Word events carry the already-advanced time; the address steps after use.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      cur_addr    <= '0;
      time_acc    <= '0;
      push_q      <= 1'b0;
      push_hdr_q  <= '0;
      push_time_q <= '0;
    end else if (clear) begin
      cur_addr    <= '0;
      time_acc    <= '0;
      push_q      <= 1'b0;
      push_hdr_q  <= '0;
      push_time_q <= '0;
    end else begin
      push_q <= is_word;
      if (pkt.packet_strobe) begin
        time_acc <= time_next;
        if (pkt.packet_type == PKT_ADDR) begin
          cur_addr <= pkt.packet_payload;
        end
        if (is_word) begin
          push_hdr_q.is_write <= (pkt.packet_type == PKT_WRITE);
          push_hdr_q.addr     <= cur_addr;
          push_hdr_q.ublb     <= pkt.packet_payload[UBLB_MSB:UBLB_LSB];
          push_hdr_q.data     <= pkt.packet_payload[DATA_MSB:DATA_LSB];
          push_time_q         <= time_next;
          cur_addr            <= cur_addr + ADDR_ONE;
        end
      end
    end
  end

  assign fifo_pop = !fifo_empty && pkt.ev_ready;

  trace_event_fifo #(
    .WIDTH      (EV_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .mclk      (mclk),
    .reset     (reset),
    .clear     (clear),
    .push      (push_q),
    .push_data ({push_hdr_q, push_time_q}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .overflow  (fifo_ovf)
  );

  // Head fields are forced to zero while empty so stale RAM never shows.
  assign head_hdr        = ev_hdr_t'(fifo_head[EV_WIDTH-1:TIME_WIDTH]);
  assign pkt.ev_valid    = !fifo_empty;
  assign pkt.ev_is_write = fifo_empty ? 1'b0 : head_hdr.is_write;
  assign pkt.ev_addr     = fifo_empty ? '0   : head_hdr.addr;
  assign pkt.ev_ublb     = fifo_empty ? '0   : head_hdr.ublb;
  assign pkt.ev_data     = fifo_empty ? '0   : head_hdr.data;
  assign pkt.ev_time     = fifo_empty ? '0   : fifo_head[TIME_WIDTH-1:0];

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (fifo_ovf) begin
      overflow <= 1'b1;
    end
  end

  full_implies_valid_a: assert property (@(posedge mclk) disable iff (reset)
    fifo_full |-> pkt.ev_valid);

`ifdef TRACE_DECODER_STATS_EN
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_drops  <= '0;
    end else if (clear) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_drops  <= '0;
    end else begin
      if (push_q && !push_hdr_q.is_write && (stat_reads != '1)) begin
        stat_reads <= stat_reads + 32'd1;
      end
      if (push_q && push_hdr_q.is_write && (stat_writes != '1)) begin
        stat_writes <= stat_writes + 32'd1;
      end
      if (fifo_ovf && (stat_drops != '1)) begin
        stat_drops <= stat_drops + 16'd1;
      end
    end
  end
`endif

endmodule
